// File: rtl/qspi_rx_deser.sv
// ============================================================================
//  Module      : qspi_rx_deser
//  Description : Quad SPI receive deserialiser. Packs single/dual/quad lane
//                samples into DATA_W-bit words (MSB- or LSB-first), queues
//                full or flushed partial words in a small output FIFO with a
//                valid/ready handshake.
//                Optional macro QSPI_RX_WORD_CNT_EN adds a saturating count
//                of successfully pushed words on word_cnt_o.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module qspi_rx_deser #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              start_i,
  input  logic [1:0]                        mode_i,
  input  logic                              msb_first_i,
  input  logic                              sample_i,
  input  logic [3:0]                        sd_i,
  input  logic                              flush_i,
  output logic [DATA_W-1:0]                 data_o,
  output logic [$clog2(DATA_W+1)-1:0]       bits_o,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   level_o,
  output logic                              busy_o,
  output logic                              overrun_o
`ifdef QSPI_RX_WORD_CNT_EN
  ,
  output logic [15:0]                       word_cnt_o
`endif
);

  localparam int CW = $clog2(DATA_W+1);
  localparam int LW = $clog2(FIFO_DEPTH+1);
  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_DUAL   = 2'b01;
  localparam logic [1:0] MODE_QUAD   = 2'b10;

  // Latched transaction configuration and shift state
  logic [1:0]        mode_lat;
  logic              msb_lat;
  logic [DATA_W-1:0] shreg;
  logic [CW-1:0]     cnt;

  // Combinational view of this cycle
  logic [1:0]        eff_mode;
  logic              eff_msb;
  logic [DATA_W-1:0] base_sh;
  logic [CW-1:0]     base_cnt;
  logic [CW-1:0]     step;
  logic [DATA_W-1:0] sh_msb;
  logic [DATA_W-1:0] sh_lsb;
  logic              do_sample;
  logic [DATA_W-1:0] sh_after;
  logic [CW-1:0]     cnt_after;
  logic              word_full;
  logic              push;
  logic [DATA_W-1:0] sh_next;
  logic [CW-1:0]     cnt_next;

  // FIFO storage and status
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [CW-1:0]     fifo_bits [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [LW-1:0]     level;
  logic [LW-1:0]     level_next;
  logic              valid;
  logic              busy;
  logic              overrun;
  logic              pop;
  logic              fifo_full;
  logic              push_ok;
  logic              drop;

  // Shift path: start clears first, then the sample is applied, then a push
  // (full word or flush) empties the shift register.
  always_comb begin
    eff_mode  = start_i ? mode_i      : mode_lat;
    eff_msb   = start_i ? msb_first_i : msb_lat;
    base_sh   = start_i ? '0 : shreg;
    base_cnt  = start_i ? '0 : cnt;
    step      = '0;
    sh_msb    = base_sh;
    sh_lsb    = base_sh;
    case (eff_mode)
      MODE_SINGLE: begin
        step   = CW'(1);
        sh_msb = {base_sh[DATA_W-2:0], sd_i[1]};
        sh_lsb = {sd_i[1], base_sh[DATA_W-1:1]};
      end
      MODE_DUAL: begin
        step   = CW'(2);
        sh_msb = {base_sh[DATA_W-3:0], sd_i[1:0]};
        sh_lsb = {sd_i[1:0], base_sh[DATA_W-1:2]};
      end
      MODE_QUAD: begin
        step   = CW'(4);
        sh_msb = {base_sh[DATA_W-5:0], sd_i};
        sh_lsb = {sd_i, base_sh[DATA_W-1:4]};
      end
      default: begin
        step   = '0;
      end
    endcase
    // Reserved lane mode swallows samples
    do_sample = sample_i && (eff_mode != 2'b11);
    sh_after  = do_sample ? (eff_msb ? sh_msb : sh_lsb) : base_sh;
    cnt_after = do_sample ? (base_cnt + step) : base_cnt;
    word_full = (cnt_after == CW'(DATA_W));
    // A flush on the completing sample pushes just the one full word
    push      = word_full || (flush_i && (cnt_after != '0));
    sh_next   = push ? '0 : sh_after;
    cnt_next  = push ? '0 : cnt_after;
  end

  // FIFO bookkeeping: a pop in the same cycle frees the slot for a push
  always_comb begin
    pop       = valid && ready_i;
    fifo_full = (level == LW'(FIFO_DEPTH));
    push_ok   = push && (!fifo_full || pop);
    drop      = push && !push_ok;
    level_next = level;
    case ({push_ok, pop})
      2'b10:   level_next = level + LW'(1);
      2'b01:   level_next = level - LW'(1);
      default: level_next = level;
    endcase
  end

  // Shift register, bit count and latched configuration
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mode_lat <= MODE_QUAD;
      msb_lat  <= 1'b1;
      shreg    <= '0;
      cnt      <= '0;
    end else begin
      if (start_i) begin
        mode_lat <= mode_i;
        msb_lat  <= msb_first_i;
      end
      shreg <= sh_next;
      cnt   <= cnt_next;
    end
  end

  // FIFO storage and pointers; entries are cleared on reset so the head reads 0
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_bits[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push_ok) begin
        fifo_data[wr_ptr] <= sh_after;
        fifo_bits[wr_ptr] <= cnt_after;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Registered status flags; a drop in the start cycle still reports overrun
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      level   <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      level   <= level_next;
      valid   <= (level_next != '0);
      busy    <= (cnt_next != '0);
      overrun <= (overrun && !start_i) || drop;
    end
  end

`ifdef QSPI_RX_WORD_CNT_EN
  logic [15:0] word_cnt;

  // Saturating count of accepted pushes, restarted by each new transaction
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      word_cnt <= '0;
    end else begin
      if (start_i) begin
        word_cnt <= push_ok ? 16'd1 : 16'd0;
      end else if (push_ok && (word_cnt != 16'hFFFF)) begin
        word_cnt <= word_cnt + 16'd1;
      end
    end
  end

  assign word_cnt_o = word_cnt;
`endif

  assign data_o    = fifo_data[rd_ptr];
  assign bits_o    = fifo_bits[rd_ptr];
  assign valid_o   = valid;
  assign level_o   = level;
  assign busy_o    = busy;
  assign overrun_o = overrun;

endmodule

`default_nettype wire

// File: tb/tb_qspi_rx_deser.sv
// ============================================================================
//  Module      : tb_qspi_rx_deser
//  Description : Directed self-checking bench for qspi_rx_deser
//                (DATA_W=32, FIFO_DEPTH=4, default build).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_qspi_rx_deser;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [1:0]  mode_i = 2'b10;
  logic        msb_first_i = 1'b1;
  logic        sample_i = 1'b0;
  logic [3:0]  sd_i = 4'h0;
  logic        flush_i = 1'b0;
  logic [31:0] data_o;
  logic [5:0]  bits_o;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [2:0]  level_o;
  logic        busy_o;
  logic        overrun_o;

  int n_tests = 0;
  int n_fail  = 0;

  qspi_rx_deser #(.DATA_W(32), .FIFO_DEPTH(4)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .mode_i      (mode_i),
    .msb_first_i (msb_first_i),
    .sample_i    (sample_i),
    .sd_i        (sd_i),
    .flush_i     (flush_i),
    .data_o      (data_o),
    .bits_o      (bits_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .level_o     (level_o),
    .busy_o      (busy_o),
    .overrun_o   (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock; outputs are observed 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Start a transaction, then put noise on mode/order to show it is ignored
  task automatic do_start(input logic [1:0] m, input logic msb);
    start_i = 1'b1; mode_i = m; msb_first_i = msb;
    tick();
    start_i = 1'b0; mode_i = 2'b11; msb_first_i = ~msb;
  endtask

  task automatic do_sample(input logic [3:0] v);
    sample_i = 1'b1; sd_i = v;
    tick();
    sample_i = 1'b0; sd_i = 4'h0;
  endtask

  task automatic do_flush();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
  endtask

  task automatic pop_one();
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
  endtask

  task automatic quad_word(input logic [31:0] w);
    for (int i = 7; i >= 0; i--) do_sample(w[i*4 +: 4]);
  endtask

  logic [31:0] pat;
  logic        b;

  initial begin
    // Reset state
    #1;
    check("rst_data",  data_o, 0);
    check("rst_bits",  bits_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_level", level_o, 0);
    check("rst_busy",  busy_o, 0);
    check("rst_ovr",   overrun_o, 0);
    tick(); tick();
    rst_i = 1'b0;

    // Quad MSB-first: nibbles 1..8
    do_start(2'b10, 1'b1);
    for (int i = 1; i <= 7; i++) do_sample(4'(i));
    check("q_msb_valid_early", valid_o, 0);
    check("q_msb_busy", busy_o, 1);
    do_sample(4'd8);
    check("q_msb_valid", valid_o, 1);
    check("q_msb_data",  data_o, 32'h12345678);
    check("q_msb_bits",  bits_o, 32);
    check("q_msb_level", level_o, 1);
    check("q_msb_busy0", busy_o, 0);
    pop_one();
    check("q_msb_popped", valid_o, 0);

    // Quad LSB-first: same nibbles
    do_start(2'b10, 1'b0);
    for (int i = 1; i <= 8; i++) do_sample(4'(i));
    check("q_lsb_data", data_o, 32'h87654321);
    pop_one();

    // Single lane MSB-first, noise on the unused lane 0
    do_start(2'b00, 1'b1);
    pat = 32'hA5A5A5A5;
    for (int i = 31; i >= 0; i--) begin
      b = pat[i];
      do_sample({2'b00, b, ~b});
    end
    check("single_data", data_o, 32'hA5A5A5A5);
    check("single_bits", bits_o, 32);
    pop_one();

    // Dual lane MSB-first
    do_start(2'b01, 1'b1);
    for (int i = 0; i < 16; i++) do_sample(4'b0011);
    check("dual_data", data_o, 32'hFFFFFFFF);
    pop_one();

    // Partial flush, quad MSB-first: right-aligned
    do_start(2'b10, 1'b1);
    do_sample(4'hA); do_sample(4'hB); do_sample(4'hC);
    check("flush_busy", busy_o, 1);
    do_flush();
    check("flush_data", data_o, 32'h00000ABC);
    check("flush_bits", bits_o, 12);
    check("flush_busy0", busy_o, 0);
    pop_one();

    // Flush in the same cycle as the 4th sample
    do_sample(4'hA); do_sample(4'hB); do_sample(4'hC);
    flush_i = 1'b1; do_sample(4'hD); flush_i = 1'b0;
    check("flush_smp_data", data_o, 32'h0000ABCD);
    check("flush_smp_bits", bits_o, 16);
    pop_one();

    // Flush with nothing pending does nothing
    do_flush();
    check("flush_empty_valid", valid_o, 0);
    check("flush_empty_level", level_o, 0);

    // Partial flush, quad LSB-first: left-aligned
    do_start(2'b10, 1'b0);
    do_sample(4'hA); do_sample(4'hB); do_sample(4'hC);
    do_flush();
    check("lsb_flush_data", data_o, 32'hCBA00000);
    check("lsb_flush_bits", bits_o, 12);
    pop_one();

    // Start with a simultaneous sample discards the partial word in progress
    do_start(2'b10, 1'b1);
    do_sample(4'hE); do_sample(4'hF);
    start_i = 1'b1; mode_i = 2'b10; msb_first_i = 1'b1;
    do_sample(4'h7);
    start_i = 1'b0; mode_i = 2'b11;
    for (int i = 1; i <= 7; i++) do_sample(4'(i));
    check("start_smp_data", data_o, 32'h71234567);
    pop_one();

    // Reserved mode ignores samples
    do_start(2'b11, 1'b1);
    for (int i = 0; i < 8; i++) do_sample(4'hF);
    check("rsvd_busy",  busy_o, 0);
    check("rsvd_level", level_o, 0);

    // Overrun: five words into a four-deep FIFO with no consumer
    do_start(2'b10, 1'b1);
    for (int w = 1; w <= 4; w++) quad_word({8{4'(w)}});
    check("ovr_level4", level_o, 4);
    check("ovr_flag0",  overrun_o, 0);
    quad_word(32'h55555555);
    check("ovr_level",  level_o, 4);
    check("ovr_flag",   overrun_o, 1);
    check("ovr_busy",   busy_o, 0);
    do_start(2'b10, 1'b1);
    check("ovr_clr",       overrun_o, 0);
    check("ovr_level_kept", level_o, 4);
    ready_i = 1'b1;
    for (int w = 1; w <= 4; w++) begin
      pat = {8{4'(w)}};
      check("ovr_drain", data_o, pat);
      tick();
    end
    ready_i = 1'b0;
    check("ovr_drain_level", level_o, 0);
    check("ovr_drain_valid", valid_o, 0);

    // Push and pop together on a full FIFO
    for (int w = 1; w <= 4; w++) quad_word({8{4'(w)}});
    for (int i = 0; i < 7; i++) do_sample(4'h9);
    ready_i = 1'b1;
    do_sample(4'h9);
    ready_i = 1'b0;
    check("pp_level", level_o, 4);
    check("pp_ovr",   overrun_o, 0);
    check("pp_head",  data_o, 32'h22222222);
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    ready_i = 1'b0;
    check("pp_empty", level_o, 0);

    // Asynchronous reset mid-word with two words queued
    quad_word(32'h13579BDF);
    quad_word(32'h2468ACE0);
    do_sample(4'h1); do_sample(4'h2); do_sample(4'h3);
    check("prerst_level", level_o, 2);
    #2 rst_i = 1'b1;
    #1;
    check("arst_data",  data_o, 0);
    check("arst_bits",  bits_o, 0);
    check("arst_valid", valid_o, 0);
    check("arst_level", level_o, 0);
    check("arst_busy",  busy_o, 0);
    rst_i = 1'b0;
    quad_word(32'h9ABCDEF0);
    check("post_rst_level", level_o, 1);
    check("post_rst_data",  data_o, 32'h9ABCDEF0);
    check("post_rst_bits",  bits_o, 32);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/qspi_rx_deser.md
# qspi_rx_deser

Parametrised receive deserialiser for the Quad SPI controller. It captures single, dual or quad lane input samples into words of programmable width, in MSB-first or LSB-first order, and queues completed or flushed words in an output FIFO with a valid/ready handshake. It sits between the SPI pad sampling logic (which supplies `sample_i` strobes) and the register/bus-side RX data path.

## Interface
- `DATA_W`, 32: word width in bits; multiple of 4, minimum 8.
- `FIFO_DEPTH`, 4: output FIFO entries; power of two, minimum 2.
- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `start_i`  in  1  new transaction: clear shift register, bit count and `overrun_o`; latch `mode_i` and `msb_first_i`.
- `mode_i`  in  2  lane mode: 00 single (uses `sd_i[1]`), 01 dual (`sd_i[1:0]`), 10 quad (`sd_i[3:0]`), 11 reserved.
- `msb_first_i`  in  1  1 = shift left and insert at LSBs; 0 = shift right and insert at MSBs.
- `sample_i`  in  1  `sd_i` holds a valid sample this cycle.
- `sd_i`  in  4  lane data.
- `flush_i`  in  1  push a partial word, if any.
- `data_o`  out  DATA_W  FIFO head data.
- `bits_o`  out  $clog2(DATA_W+1)  valid bit count of the head entry.
- `valid_o`  out  1  FIFO non-empty.
- `ready_i`  in  1  consumer accepts the head when `valid_o` is high.
- `level_o`  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy.
- `busy_o`  out  1  partial word pending (bit count > 0).
- `overrun_o`  out  1  sticky: a word was dropped because the FIFO was full.

## Operation
- Lanes per sample k = 1/2/4 from the latched mode. Reset value of the latched mode is quad, MSB-first.
- The latched mode 11 ignores `sample_i`.
- On a sample:
  - MSB-first: `shreg <= {shreg[DATA_W-k-1:0], lanes}`.
  - LSB-first: `shreg <= {lanes, shreg[DATA_W-1:k]}`.
  - `cnt += k`.
- Word complete when `cnt` reaches DATA_W:
  - Push {shreg, DATA_W} to the FIFO.
  - Clear `shreg` and `cnt` in the same cycle.
- Flush with `cnt > 0`:
  - Push the shift register exactly as it stands, with `bits_o = cnt`. MSB-first data is right-aligned; LSB-first data is left-aligned; unused bits are 0.
  - Then clear `shreg` and `cnt`.
  - Flush with `cnt == 0` does nothing.
- Simultaneous events:
  - `start_i` + `sample_i`: clear first, then the sample is the first sample of the new word, using the newly latched mode and order.
  - `sample_i` + `flush_i`: the sample is applied first. If that completes the word, one full word is pushed; otherwise a partial word with `cnt + k` bits is pushed.
  - Push + pop on a full FIFO: the pop frees the slot and the push succeeds.
- Push with the FIFO full and no pop: the word is dropped, `overrun_o` is set, and the shift register still clears.
- `start_i` does not touch FIFO contents. Only reset empties the FIFO.
- A change to `mode_i` or `msb_first_i` without `start_i` has no effect.
- Reset values: `data_o` 0, `bits_o` 0, `valid_o` 0, `level_o` 0, `busy_o` 0, `overrun_o` 0.

## Timing
- Pushed word visible at the FIFO head (`valid_o` 1) one cycle after the completing sample or flush cycle.
- Pop on the rising edge where `valid_o & ready_i`; the next entry appears the following cycle.
- FIFO read pointer and write pointer each wrap modulo FIFO_DEPTH.
- `level_o` and `valid_o` are registered, updated the cycle after the push or pop.
- Throughput: one word per DATA_W/k sample cycles, with no bubbles while `ready_i` stays high.
- `busy_o` tracks `cnt != 0` registered.
- Reset asserted mid-word aborts immediately: all state returns to reset values, asynchronously.

## Configuration
- `QSPI_RX_WORD_CNT_EN`:
  - Defined: adds output `word_cnt_o` [15:0]. It counts words successfully pushed (full or partial), saturates at 0xFFFF, and clears on `start_i` and on reset.
  - Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Quad, MSB-first, DATA_W=32:
  - Stimulus: `start_i`, then 8 consecutive samples of nibbles 1,2,…,8.
  - Response: `data_o` = 0x12345678, `bits_o` = 32, `valid_o` rises the cycle after the 8th sample.
- Quad, LSB-first:
  - Stimulus: the same nibbles.
  - Response: `data_o` = 0x87654321.
- Single then dual, MSB-first:
  - Single: 32 samples of the bits of 0xA5A5A5A5 on `sd_i[1]` give 0xA5A5A5A5.
  - Dual: 16 samples of 2'b11 give 0xFFFFFFFF.
- Partial flush, quad MSB-first:
  - Stimulus: samples A, B, C, then `flush_i`.
  - Response: `data_o` = 0x00000ABC, `bits_o` = 12, `busy_o` returns to 0.
  - Flush together with sample D after A, B, C gives 0x0000ABCD, `bits_o` = 16.
- Overrun, `ready_i` = 0, FIFO_DEPTH = 4:
  - Stimulus: 5 quad words.
  - Response: `level_o` = 4, 5th word dropped, `overrun_o` = 1.
  - Follow-up: `start_i` clears `overrun_o`; `level_o` stays 4; with `ready_i` = 1 the first four words drain in order.
- Reset mid-word:
  - Stimulus: assert `rst_i` after 3 quad samples with 2 words queued.
  - Response: all outputs 0 with no clock edge required. After release, 8 new samples produce exactly one word.
